// File: rtl/systolic_skew_feeder_pkg.sv
// Shared constants, FSM encoding and element indexing for the skew feeder.
package systolic_skew_feeder_pkg;

    localparam int unsigned N      = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NELEM  = N * N;
    localparam int unsigned ADDR_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StDone
    } feed_state_e;

    // Row-major element index r*3+c.
    function automatic logic [ADDR_W-1:0] idx(input int r, input int c);
        return ADDR_W'(r * int'(N) + c);
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Write port, start/status and skewed stream bundle between controller and feeder.
interface systolic_skew_feeder_if;
    import systolic_skew_feeder_pkg::*;

    logic              wr_en;
    logic              wr_sel;
    logic [3:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              busy;
    logic              feed_valid;
    logic [DATA_W-1:0] inp_west0;
    logic [DATA_W-1:0] inp_west3;
    logic [DATA_W-1:0] inp_west6;
    logic [DATA_W-1:0] inp_north0;
    logic [DATA_W-1:0] inp_north1;
    logic [DATA_W-1:0] inp_north2;
    logic              done;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start,
        input  busy, feed_valid, inp_west0, inp_west3, inp_west6,
               inp_north0, inp_north1, inp_north2, done
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start,
        output busy, feed_valid, inp_west0, inp_west3, inp_west6,
               inp_north0, inp_north1, inp_north2, done
    );

endinterface

// File: rtl/systolic_skew_feeder_skew_mat_store.sv
// 3x3 matrix register file: one write port, three combinational read ports.
module systolic_skew_feeder_skew_mat_store
    import systolic_skew_feeder_pkg::*;
(
    input  logic                         i_clk,
    input  logic                         i_we,
    input  logic [ADDR_W-1:0]            i_waddr,
    input  logic [DATA_W-1:0]            i_wdata,
    input  logic [N-1:0][ADDR_W-1:0]     i_raddr,
    output logic [N-1:0][DATA_W-1:0]     o_rdata
);

    // Storage is deliberately not reset; contents survive a reset so a feed can be replayed.
    logic [DATA_W-1:0] r_mem [NELEM];

    // Element write, out-of-range addresses dropped.
    always_ff @(posedge i_clk) begin
        if (i_we && (i_waddr < ADDR_W'(NELEM))) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Three independent read ports.
    always_comb begin
        for (int p = 0; p < int'(N); p++) begin
            o_rdata[p] = '0;
            if (i_raddr[p] < ADDR_W'(NELEM)) begin
                o_rdata[p] = r_mem[i_raddr[p]];
            end
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Feeds a 3x3 systolic array with diagonally skewed A rows (west) and B columns (north).
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int unsigned DRAIN_CYC = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    systolic_skew_feeder_if.slave  io_bus
);

    localparam int unsigned LastK  = 2 * N - 2;
    localparam int unsigned CntMax = (LastK > DRAIN_CYC - 1) ? LastK : DRAIN_CYC - 1;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    feed_state_e                r_state, w_state_d;
    logic [CntW-1:0]            r_cnt, w_cnt_d;
    logic                       w_load;
    logic                       w_wr_accept;
    logic [N-1:0]               w_a_ok, w_b_ok;
    logic [N-1:0][ADDR_W-1:0]   w_a_raddr, w_b_raddr;
    logic [N-1:0][DATA_W-1:0]   w_a_rdata, w_b_rdata;
    logic [N-1:0][DATA_W-1:0]   w_west_d, w_north_d;
    logic [N-1:0][DATA_W-1:0]   r_west, r_north;

    // A start in the same cycle as a write loses to the write.
    assign w_wr_accept = io_bus.wr_en && (r_state == StIdle)
                         && (io_bus.wr_addr <= ADDR_W'(NELEM - 1));

    systolic_skew_feeder_skew_mat_store u_store_a (
        .i_clk   (i_clk),
        .i_we    (w_wr_accept && !io_bus.wr_sel),
        .i_waddr (io_bus.wr_addr),
        .i_wdata (io_bus.wr_data),
        .i_raddr (w_a_raddr),
        .o_rdata (w_a_rdata)
    );

    systolic_skew_feeder_skew_mat_store u_store_b (
        .i_clk   (i_clk),
        .i_we    (w_wr_accept && io_bus.wr_sel),
        .i_waddr (io_bus.wr_addr),
        .i_wdata (io_bus.wr_data),
        .i_raddr (w_b_raddr),
        .o_rdata (w_b_rdata)
    );

    // Next state and step counter; w_load marks an edge that enters a feed step.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_load    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (io_bus.start && !io_bus.wr_en) begin
                    w_state_d = StFeed;
                    w_cnt_d   = '0;
                    w_load    = 1'b1;
                end
            end
            StFeed: begin
                if (r_cnt == CntW'(LastK)) begin
                    w_state_d = StDrain;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                    w_load  = 1'b1;
                end
            end
            StDrain: begin
                if (r_cnt == CntW'(DRAIN_CYC - 1)) begin
                    w_state_d = StDone;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StDone: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Skew addressing for the upcoming step: west_i = A[i][k-i], north_j = B[k-j][j].
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            w_a_ok[i]    = 1'b0;
            w_b_ok[i]    = 1'b0;
            w_a_raddr[i] = '0;
            w_b_raddr[i] = '0;
            if ((int'(w_cnt_d) >= i) && (int'(w_cnt_d) < i + int'(N))) begin
                w_a_ok[i]    = 1'b1;
                w_b_ok[i]    = 1'b1;
                w_a_raddr[i] = idx(i, int'(w_cnt_d) - i);
                w_b_raddr[i] = idx(int'(w_cnt_d) - i, i);
            end
        end
    end

    // Stream data, zero outside feed steps and outside the diagonal band.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            w_west_d[i]  = (w_load && w_a_ok[i]) ? w_a_rdata[i] : '0;
            w_north_d[i] = (w_load && w_b_ok[i]) ? w_b_rdata[i] : '0;
        end
    end

    // State, counter and registered stream outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_west  <= '0;
            r_north <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_west  <= w_west_d;
            r_north <= w_north_d;
        end
    end

    assign io_bus.busy       = (r_state == StFeed) || (r_state == StDrain);
    assign io_bus.feed_valid = (r_state == StFeed);
    assign io_bus.done       = (r_state == StDone);
    assign io_bus.inp_west0  = r_west[0];
    assign io_bus.inp_west3  = r_west[1];
    assign io_bus.inp_west6  = r_west[2];
    assign io_bus.inp_north0 = r_north[0];
    assign io_bus.inp_north1 = r_north[1];
    assign io_bus.inp_north2 = r_north[2];

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: default build and a DRAIN_CYC=1 build share stimulus.
module tb_systolic_skew_feeder;
    import systolic_skew_feeder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_skew_feeder_if bus0 ();
    systolic_skew_feeder_if bus1 ();

    assign bus1.wr_en   = bus0.wr_en;
    assign bus1.wr_sel  = bus0.wr_sel;
    assign bus1.wr_addr = bus0.wr_addr;
    assign bus1.wr_data = bus0.wr_data;
    assign bus1.start   = bus0.start;

    systolic_skew_feeder #(.DRAIN_CYC(4)) dut0 (.i_clk(clk), .i_rst(rst), .io_bus(bus0));
    systolic_skew_feeder #(.DRAIN_CYC(1)) dut1 (.i_clk(clk), .i_rst(rst), .io_bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: per build, its own copy of A/B and cycles elapsed since start (0 = idle).
    logic [31:0] ma [2][9];
    logic [31:0] mb [2][9];
    int          ph [2]   = '{0, 0};
    int          dcyc [2] = '{4, 1};

    task automatic check(input string tag, input logic [194:0] got, input logic [194:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Elapsed cycle p: steps at p=1..5, drain after, done at 6+D. A[i][c] is on west_i
    // and B[r][j] on north_j at step i+c / r+j.
    function automatic logic [194:0] exp_out(input int d);
        logic [31:0] w [3];
        logic [31:0] n [3];
        int          p;
        int          k;
        logic        fv;
        logic        bz;
        logic        dn;
        p  = ph[d];
        k  = p - 1;
        fv = (p >= 1) && (p <= 5);
        bz = (p >= 1) && (p <= 5 + dcyc[d]);
        dn = (p == 6 + dcyc[d]);
        for (int i = 0; i < 3; i++) begin
            w[i] = '0;
            n[i] = '0;
        end
        if (fv) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    if (r + c == k) begin
                        w[r] = ma[d][r * 3 + c];
                        n[c] = mb[d][r * 3 + c];
                    end
                end
            end
        end
        return {bz, fv, dn, w[0], w[1], w[2], n[0], n[1], n[2]};
    endfunction

    function automatic logic [194:0] dut_out(input int d);
        if (d == 0) begin
            return {bus0.busy, bus0.feed_valid, bus0.done, bus0.inp_west0, bus0.inp_west3,
                    bus0.inp_west6, bus0.inp_north0, bus0.inp_north1, bus0.inp_north2};
        end
        return {bus1.busy, bus1.feed_valid, bus1.done, bus1.inp_west0, bus1.inp_west3,
                bus1.inp_west6, bus1.inp_north0, bus1.inp_north1, bus1.inp_north2};
    endfunction

    task automatic model_step(input int d);
        if (ph[d] == 0) begin
            if (bus0.wr_en) begin
                if (bus0.wr_addr <= 4'd8) begin
                    if (bus0.wr_sel) mb[d][bus0.wr_addr] = bus0.wr_data;
                    else             ma[d][bus0.wr_addr] = bus0.wr_data;
                end
            end else if (bus0.start) begin
                ph[d] = 1;
            end
        end else if (ph[d] == 6 + dcyc[d]) begin
            ph[d] = 0;
        end else begin
            ph[d] = ph[d] + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        check("stream_d4", dut_out(0), exp_out(0));
        check("stream_d1", dut_out(1), exp_out(1));
    endtask

    task automatic do_write(input logic sel, input logic [3:0] addr, input logic [31:0] data);
        bus0.wr_en   = 1'b1;
        bus0.wr_sel  = sel;
        bus0.wr_addr = addr;
        bus0.wr_data = data;
        tick();
        bus0.wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40 && (ph[0] != 0 || ph[1] != 0); n++) tick();
    endtask

    task automatic start_feed();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
    endtask

    int lat0;
    int lat1;
    int dn0;
    int dn1;

    initial begin
        bus0.wr_en   = 1'b0;
        bus0.wr_sel  = 1'b0;
        bus0.wr_addr = '0;
        bus0.wr_data = '0;
        bus0.start   = 1'b0;
        #2 rst = 1'b0;
        #1 check("reset", dut_out(0), '0);
        tick();
        rst = 1'b1;
        tick();

        // Case 1: A=1..9, B=10..18; check latency to done on both builds.
        for (int e = 0; e < 9; e++) do_write(1'b0, 4'(e), 32'(e + 1));
        for (int e = 0; e < 9; e++) do_write(1'b1, 4'(e), 32'(e + 10));
        lat0 = -1;
        lat1 = -1;
        start_feed();
        check("first_west0", 195'(bus0.inp_west0), 195'(1));
        for (int n = 1; n <= 12; n++) begin
            if (bus0.done && lat0 < 0) lat0 = n;
            if (bus1.done && lat1 < 0) lat1 = n;
            tick();
        end
        check("latency_d4", 195'(lat0), 195'(10));
        check("latency_d1", 195'(lat1), 195'(7));

        // Case 2: start held high.
        wait_idle();
        dn0 = 0;
        dn1 = 0;
        bus0.start = 1'b1;
        for (int n = 0; n < 33; n++) begin
            tick();
            dn0 += int'(bus0.done);
            dn1 += int'(bus1.done);
        end
        bus0.start = 1'b0;
        check("held_done_d4", 195'(dn0), 195'(3));
        check("held_done_d1", 195'(dn1), 195'(4));

        // Case 3: write during FEED and out-of-range write are ignored.
        wait_idle();
        start_feed();
        tick();
        do_write(1'b0, 4'd0, 32'd99);
        wait_idle();
        do_write(1'b0, 4'd12, 32'hdead_beef);
        do_write(1'b1, 4'd15, 32'hdead_beef);
        start_feed();
        check("replay_a0", 195'(bus0.inp_west0), 195'(1));
        wait_idle();

        // Case 4: start and write together.
        bus0.start = 1'b1;
        do_write(1'b0, 4'd0, 32'd77);
        bus0.start = 1'b0;
        check("start_with_wr_busy", 195'(bus0.busy), 195'(0));
        start_feed();
        check("new_a0", 195'(bus0.inp_west0), 195'(77));
        wait_idle();
        do_write(1'b0, 4'd0, 32'd1);

        // Case 5: reset at feed step 2, then replay.
        start_feed();
        tick();
        tick();
        rst = 1'b0;
        #1;
        ph[0] = 0;
        ph[1] = 0;
        check("async_rst_d4", dut_out(0), '0);
        check("async_rst_d1", dut_out(1), '0);
        tick();
        tick();
        rst = 1'b1;
        start_feed();
        check("replay_north2_step0", 195'(bus0.inp_north2), 195'(0));
        check("replay_north0_step0", 195'(bus0.inp_north0), 195'(10));
        wait_idle();

        // Randomized matrices and traffic.
        for (int e = 0; e < 9; e++) do_write(1'b0, 4'(e), $urandom);
        for (int e = 0; e < 9; e++) do_write(1'b1, 4'(e), $urandom);
        for (int n = 0; n < 400; n++) begin
            bus0.wr_en   = ($urandom_range(0, 3) == 0);
            bus0.wr_sel  = 1'($urandom_range(0, 1));
            bus0.wr_addr = 4'($urandom_range(0, 15));
            bus0.wr_data = $urandom;
            bus0.start   = ($urandom_range(0, 4) == 0);
            tick();
        end
        bus0.wr_en = 1'b0;
        bus0.start = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
